fifo_wr_arbiter: RTL

- Round-robin arbiter sharing the FIFO write port between N_REQ requesters, all in the wr_clk domain.
- Grants one requester at a time for a burst, then forwards its data and valid/ready handshake to the FIFO write side (fifo_wr_en, fifo_wr_data).
- Honours the FIFO full flag, so no write is issued while full.
- Sits directly in front of the FIFO write logic.

---
 rtl/fifo_wr_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ requesters.
// A grant lasts until the grantee's req_last beat or MAX_BURST beats, whichever comes first.
module fifo_wr_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4,
    localparam int unsigned GNT_W    = $clog2(N_REQ)
) (
    input  logic                      wr_clk,
    input  logic                      wr_rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_last,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_wr_data,
    output logic [GNT_W-1:0]          grant_id,
    output logic                      busy
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    logic [0:0]        state;
    logic [0:0]        state_nx;
    logic [GNT_W-1:0]  rr_ptr;
    logic [GNT_W-1:0]  rr_ptr_nx;
    logic [GNT_W-1:0]  grant_nx;
    logic [CNT_W-1:0]  beat_cnt;
    logic [CNT_W-1:0]  beat_cnt_nx;

    logic [N_REQ-1:0]  hi_valid;
    logic [GNT_W-1:0]  pick_hi;
    logic [GNT_W-1:0]  pick_any;
    logic [GNT_W-1:0]  pick;

    logic              sel_valid;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;
    logic              burst_done;

    // Cyclic search from rr_ptr+1: prefer the lowest valid index above the pointer,
    // otherwise wrap to the lowest valid index overall.
    always_comb begin : rr_pick
        hi_valid = '0;
        pick_hi  = '0;
        pick_any = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            hi_valid[i] = req_valid[i] && (GNT_W'(i) > rr_ptr);
        end
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (hi_valid[i]) begin
                pick_hi = GNT_W'(i);
            end
            if (req_valid[i]) begin
                pick_any = GNT_W'(i);
            end
        end
        pick = (|hi_valid) ? pick_hi : pick_any;
    end

    // Mux out the current grantee's request lane.
    always_comb begin : grant_mux
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (GNT_W'(i) == grant_id) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign burst_done = sel_last || (beat_cnt == CNT_W'(MAX_BURST - 1));

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin : fsm_reg
        if (!wr_rst_n) begin
            state    <= ST_IDLE;
            rr_ptr   <= GNT_W'(N_REQ - 1);
            grant_id <= '0;
            beat_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            rr_ptr   <= rr_ptr_nx;
            grant_id <= grant_nx;
            beat_cnt <= beat_cnt_nx;
            busy     <= (state_nx == ST_XFER);
        end
    end

    // Next state plus the handshake outputs, which must react to fifo_full in the same cycle.
    always_comb begin : fsm_comb
        state_nx     = state;
        rr_ptr_nx    = rr_ptr;
        grant_nx     = grant_id;
        beat_cnt_nx  = beat_cnt;
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;

        case (state)
            ST_IDLE: begin
                if (|req_valid) begin
                    state_nx    = ST_XFER;
                    grant_nx    = pick;
                    rr_ptr_nx   = pick;
                    beat_cnt_nx = '0;
                end
            end
            ST_XFER: begin
                fifo_wr_data = sel_data;
                for (int i = 0; i < int'(N_REQ); i++) begin
                    if (GNT_W'(i) == grant_id) begin
                        req_ready[i] = ~fifo_full;
                    end
                end
                fifo_wr_en = sel_valid & ~fifo_full;
                if (fifo_wr_en) begin
                    if (burst_done) begin
                        state_nx    = ST_IDLE;
                        beat_cnt_nx = '0;
                    end else begin
                        beat_cnt_nx = beat_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule
